// File: rtl/mem_arbiter.sv
// Three-way arbiter and access sequencer for the shared single-port memory (fetch, data, debug).
// Define ARB_FIXED_PRIO_EN for fixed priority debug > data > fetch; default build is round-robin.
module mem_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [2:0]        we,
    input  logic [3*AW-1:0]   addr,
    input  logic [3*DW-1:0]   wdata,
    output logic [2:0]        ack,
    output logic [DW-1:0]     rdata,
    output logic [2:0]        grant,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t          state_r;
    logic [2:0]      cnt_r;
    logic [2:0]      ack_r;
    logic [2:0]      grant_r;
    logic            busy_r;
    logic            mem_en_r;
    logic            mem_we_r;
    logic [AW-1:0]   mem_addr_r;
    logic [DW-1:0]   mem_wdata_r;
    logic [DW-1:0]   rdata_r;
`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]      ptr_r;
`endif

    logic [2:0]      win_s;
    logic [2:0]      we_eff_s;
    logic            win_we_s;
    logic [AW-1:0]   win_addr_s;
    logic [DW-1:0]   win_wdata_s;

`ifdef ARB_FIXED_PRIO_EN
    function automatic logic [2:0] pick_fixed(input logic [2:0] r);
        logic [2:0] g;
        if (r[2]) begin
            g = 3'b100;
        end else if (r[1]) begin
            g = 3'b010;
        end else if (r[0]) begin
            g = 3'b001;
        end else begin
            g = 3'b000;
        end
        return g;
    endfunction
`else
    // Rotate so the pointer position is bit 0, take the lowest set bit, rotate back.
    function automatic logic [2:0] pick_rr(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] rot;
        logic [2:0] g_rot;
        logic [2:0] g;
        case (p)
            2'd1:    rot = {r[0], r[2], r[1]};
            2'd2:    rot = {r[1], r[0], r[2]};
            default: rot = r;
        endcase
        if (rot[0]) begin
            g_rot = 3'b001;
        end else if (rot[1]) begin
            g_rot = 3'b010;
        end else if (rot[2]) begin
            g_rot = 3'b100;
        end else begin
            g_rot = 3'b000;
        end
        case (p)
            2'd1:    g = {g_rot[1], g_rot[0], g_rot[2]};
            2'd2:    g = {g_rot[0], g_rot[2], g_rot[1]};
            default: g = g_rot;
        endcase
        return g;
    endfunction

    function automatic logic [1:0] next_ptr(input logic [2:0] g);
        logic [1:0] p;
        case (g)
            3'b001:  p = 2'd1;
            3'b010:  p = 2'd2;
            default: p = 2'd0;
        endcase
        return p;
    endfunction
`endif

    // Winner selection and the winner's address/write data/write enable.
    always_comb begin
        win_s       = 3'b000;
        we_eff_s    = we & 3'b110;
        win_we_s    = 1'b0;
        win_addr_s  = addr[AW-1:0];
        win_wdata_s = wdata[DW-1:0];
`ifdef ARB_FIXED_PRIO_EN
        // An acked requester that is still the top priority goes back through IDLE instead of yielding.
        if (state_r == DONE) begin
            if (pick_fixed(req) == grant_r) begin
                win_s = 3'b000;
            end else begin
                win_s = pick_fixed(req);
            end
        end else if (state_r == IDLE) begin
            win_s = pick_fixed(req);
        end else begin
            win_s = 3'b000;
        end
`else
        if (state_r == DONE) begin
            win_s = pick_rr(req & ~grant_r, ptr_r);
        end else if (state_r == IDLE) begin
            win_s = pick_rr(req, ptr_r);
        end else begin
            win_s = 3'b000;
        end
`endif
        case (win_s)
            3'b010: begin
                win_we_s    = we_eff_s[1];
                win_addr_s  = addr[2*AW-1:AW];
                win_wdata_s = wdata[2*DW-1:DW];
            end
            3'b100: begin
                win_we_s    = we_eff_s[2];
                win_addr_s  = addr[3*AW-1:2*AW];
                win_wdata_s = wdata[3*DW-1:2*DW];
            end
            default: begin
                win_we_s    = we_eff_s[0];
                win_addr_s  = addr[AW-1:0];
                win_wdata_s = wdata[DW-1:0];
            end
        endcase
    end

    // Access sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            ack_r       <= 3'b000;
            grant_r     <= 3'b000;
            busy_r      <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            rdata_r     <= {DW{1'b0}};
`ifndef ARB_FIXED_PRIO_EN
            ptr_r       <= 2'd0;
`endif
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    ack_r <= 3'b000;
                    if (|win_s) begin
                        state_r     <= ISSUE;
                        grant_r     <= win_s;
                        busy_r      <= 1'b1;
                        mem_en_r    <= 1'b1;
                        mem_we_r    <= win_we_s;
                        mem_addr_r  <= win_addr_s;
                        mem_wdata_r <= win_wdata_s;
`ifndef ARB_FIXED_PRIO_EN
                        ptr_r       <= next_ptr(win_s);
`endif
                    end else begin
                        state_r <= IDLE;
                        grant_r <= 3'b000;
                        busy_r  <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                    cnt_r    <= LAT_M1;
                    state_r  <= WAIT;
                end
                WAIT: begin
                    if (cnt_r == 3'd0) begin
                        rdata_r <= mem_rdata;
                        ack_r   <= grant_r;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    ack_r    <= 3'b000;
                    grant_r  <= 3'b000;
                    busy_r   <= 1'b0;
                    mem_en_r <= 1'b0;
                    mem_we_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_r;
    assign rdata     = rdata_r;
    assign grant     = grant_r;
    assign busy      = busy_r;
    assign mem_en    = mem_en_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;

endmodule
